// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI master arbiter: FSM state encoding and pointer sizing.
package spi_arb_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_ISSUED = 3'd2,
    ST_FEED   = 3'd3,
    ST_DRAIN  = 3'd4
  } arb_state_t;

  // Width of a client index / round-robin pointer.
  function automatic int ptr_width(input int clients);
    return (clients <= 2) ? 1 : $clog2(clients);
  endfunction

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping.
module spi_arb_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int CLIENTS = 4,
  localparam int PW = ptr_width(CLIENTS)
) (
  input  logic [CLIENTS-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [CLIENTS-1:0] o_gnt,
  output logic [PW-1:0]      o_idx
);

  logic w_found;
  int   w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < CLIENTS; i++) begin
      w_k = (int'(i_ptr) + i) % CLIENTS;
      if (!w_found && i_req[w_k]) begin
        w_found    = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = PW'(w_k);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master; each grant streams one client burst
// through the master's shadow register as a single chip-select frame.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLIENTS = 4,
  parameter int BITS    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [CLIENTS-1:0]      i_req,
  input  logic [CLIENTS*BITS-1:0] i_data,
  input  logic [CLIENTS-1:0]      i_last,
  output logic [CLIENTS-1:0]      o_ack,
  output logic [CLIENTS-1:0]      o_gnt,
  output logic [BITS-1:0]         o_rdata,
  output logic [CLIENTS-1:0]      o_rstb,
  output logic [CLIENTS-1:0]      o_cs,
  output logic [BITS-1:0]         o_m_data,
  output logic                    o_m_stb,
  input  logic                    i_m_empty,
  input  logic                    i_m_busy,
  input  logic [BITS-1:0]         i_m_data,
  input  logic                    i_m_stb
);

  localparam int PW = ptr_width(CLIENTS);

  arb_state_t         r_state, w_state_nx;
  logic [PW-1:0]      r_ptr, w_ptr_nx;
  logic [PW-1:0]      r_gidx, w_gidx_nx;
  logic [CLIENTS-1:0] r_gnt, w_gnt_nx;
  logic [CLIENTS-1:0] r_ack, w_ack_nx;
  logic               r_last_seen, w_last_nx;
  logic               r_m_stb, w_m_stb_nx;
  logic [BITS-1:0]    r_m_data, w_m_data_nx;
  logic [CLIENTS-1:0] r_rstb;
  logic [BITS-1:0]    r_rdata;

  logic [CLIENTS-1:0] w_pick_gnt;
  logic [PW-1:0]      w_pick_idx;
  logic [BITS-1:0]    w_gdata;
  logic               w_greq;
  logic               w_glast;

  spi_arb_rr_pick #(.CLIENTS(CLIENTS)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  assign w_gdata = i_data[int'(r_gidx)*BITS +: BITS];
  assign w_greq  = i_req[r_gidx];
  assign w_glast = i_last[r_gidx];

  always_comb begin
    w_state_nx  = r_state;
    w_ptr_nx    = r_ptr;
    w_gidx_nx   = r_gidx;
    w_gnt_nx    = r_gnt;
    w_last_nx   = r_last_seen;
    w_m_data_nx = r_m_data;
    w_ack_nx    = '0;
    w_m_stb_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req) begin
          w_gnt_nx   = w_pick_gnt;
          w_gidx_nx  = w_pick_idx;
          w_state_nx = ST_FIRST;
        end
      end
      ST_FIRST: begin
        w_m_data_nx = w_gdata;
        w_m_stb_nx  = 1'b1;
        w_ack_nx    = r_gnt;
        w_last_nx   = w_glast;
        w_state_nx  = ST_ISSUED;
      end
      ST_ISSUED: begin
        w_state_nx = r_last_seen ? ST_DRAIN : ST_FEED;
      end
      ST_FEED: begin
        if (!w_greq) begin
          w_state_nx = ST_DRAIN;
        end else if (i_m_busy && i_m_empty) begin
          w_m_data_nx = w_gdata;
          w_m_stb_nx  = 1'b1;
          w_ack_nx    = r_gnt;
          w_last_nx   = w_glast;
          w_state_nx  = ST_ISSUED;
        end
      end
      ST_DRAIN: begin
        // Holding off while a receive strobe is in flight keeps the final o_rstb inside the grant.
        if (!i_m_busy && !i_m_stb) begin
          w_ptr_nx   = (int'(r_gidx) == CLIENTS-1) ? '0 : r_gidx + 1'b1;
          w_gnt_nx   = '0;
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_gnt_nx   = '0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_gnt       <= '0;
      r_ack       <= '0;
      r_last_seen <= 1'b0;
      r_m_stb     <= 1'b0;
      r_m_data    <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_gidx      <= w_gidx_nx;
      r_gnt       <= w_gnt_nx;
      r_ack       <= w_ack_nx;
      r_last_seen <= w_last_nx;
      r_m_stb     <= w_m_stb_nx;
      r_m_data    <= w_m_data_nx;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rstb  <= '0;
      r_rdata <= '0;
    end else begin
      r_rstb <= '0;
      if (i_m_stb && (|r_gnt)) begin
        r_rdata <= i_m_data;
        r_rstb  <= r_gnt;
      end
    end
  end

  assign o_gnt    = r_gnt;
  assign o_ack    = r_ack;
  assign o_m_stb  = r_m_stb;
  assign o_m_data = r_m_data;
  assign o_rstb   = r_rstb;
  assign o_rdata  = r_rdata;
  assign o_cs     = ~(r_gnt & {CLIENTS{i_m_busy}});

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: behavioural SPI master with shadow register,
// burst-level client drivers and a transaction-level round-robin model.
module tb_spi_master_arbiter;

  localparam int C  = 4;
  localparam int B  = 8;
  localparam int WT = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [C-1:0]   i_req, i_last, o_ack, o_gnt, o_rstb, o_cs;
  logic [C*B-1:0] i_data;
  logic [B-1:0]   o_rdata, o_m_data, m_rx_data;
  logic           o_m_stb, m_empty, m_busy, m_rx_stb;

  always #5 clk = ~clk;

  spi_master_arbiter #(.CLIENTS(C), .BITS(B)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (i_req),
    .i_data    (i_data),
    .i_last    (i_last),
    .o_ack     (o_ack),
    .o_gnt     (o_gnt),
    .o_rdata   (o_rdata),
    .o_rstb    (o_rstb),
    .o_cs      (o_cs),
    .o_m_data  (o_m_data),
    .o_m_stb   (o_m_stb),
    .i_m_empty (m_empty),
    .i_m_busy  (m_busy),
    .i_m_data  (m_rx_data),
    .i_m_stb   (m_rx_stb)
  );

  // Master model: shifter + shadow register, slave echoes tx ^ 0x99.
  logic         m_full, m_fulln;
  logic [B-1:0] m_shadow, m_shadown, m_shreg;
  int           m_cnt;

  assign m_empty   = ~m_full;
  assign m_fulln   = m_full | (o_m_stb & m_busy);
  assign m_shadown = (o_m_stb & m_busy) ? o_m_data : m_shadow;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_full <= 1'b0; m_shadow <= '0; m_shreg <= '0;
      m_cnt <= 0; m_rx_stb <= 1'b0; m_rx_data <= '0;
    end else begin
      m_rx_stb <= 1'b0;
      m_full   <= m_fulln;
      m_shadow <= m_shadown;
      if (!m_busy) begin
        if (o_m_stb) begin
          m_shreg <= o_m_data; m_cnt <= WT; m_busy <= 1'b1;
        end
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_rx_stb  <= 1'b1;
        m_rx_data <= m_shreg ^ 8'h99;
        if (m_fulln) begin
          m_shreg <= m_shadown; m_cnt <= WT; m_full <= 1'b0;
        end else begin
          m_cnt <= 0;
        end
      end else begin
        if (m_fulln) begin
          m_shreg <= m_shadown; m_cnt <= WT; m_full <= 1'b0;
        end else begin
          m_busy <= 1'b0;
        end
      end
    end
  end

  // Client drivers
  logic [B-1:0] words [C][8];
  int  blen [C], bidx [C], acks [C], drop_at [C], left [C];
  bit  pend [C];
  bit  rand_en;

  // Monitor / reference model
  int           checks, errors;
  int           cur_g, tx_cnt, rx_cnt, exp_cnt, cs_falls, mptr, last_ntx;
  bit           stb_due;
  logic [C-1:0] prev_req, prev_gnt, prev_cs;
  int           waits [C];
  int           order [$];
  logic [B-1:0] rxq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [C-1:0] req, input int ptr);
    for (int i = 0; i < C; i++) begin
      if (req[(ptr + i) % C]) return (ptr + i) % C;
    end
    return -1;
  endfunction

  task automatic new_burst(input int k, input int len, input int drop);
    blen[k] = len; bidx[k] = 0; acks[k] = 0; drop_at[k] = drop; pend[k] = 1'b1;
    for (int i = 0; i < len; i++) words[k][i] = B'($urandom_range(0, 255));
  endtask

  task automatic drive();
    for (int k = 0; k < C; k++) begin
      i_req[k]        = pend[k];
      i_last[k]       = pend[k] && (bidx[k] == blen[k] - 1);
      i_data[k*B +: B] = words[k][bidx[k] % 8];
    end
  endtask

  task automatic arm();
    drive();
    prev_req = i_req;
  endtask

  task automatic mon_reset();
    cur_g = -1; tx_cnt = 0; rx_cnt = 0; exp_cnt = 0; cs_falls = 0; mptr = 0;
    stb_due = 1'b0; prev_gnt = '0; prev_cs = '1; rxq.delete();
    for (int k = 0; k < C; k++) waits[k] = 0;
  endtask

  task automatic clear_clients();
    for (int k = 0; k < C; k++) begin
      pend[k] = 1'b0; blen[k] = 1; bidx[k] = 0; acks[k] = 0; drop_at[k] = 0; left[k] = 0;
      for (int i = 0; i < 8; i++) words[k][i] = '0;
    end
  endtask

  task automatic step();
    int           w;
    logic [C-1:0] wm, t_cs_low, t_own;
    @(negedge clk);
    t_cs_low = ~o_cs;
    t_own    = t_cs_low & ~o_gnt;
    check("ack", o_ack, o_m_stb ? o_gnt : '0);
    check("cs_own", t_own, '0);
    check("cs_excl", $countones(t_cs_low) <= 1, 1);

    if (prev_gnt == '0 && o_gnt != '0) begin
      w  = rr_pick(prev_req, mptr);
      wm = '0;
      if (w >= 0) wm[w] = 1'b1;
      check("gnt", o_gnt, wm);
      for (int k = 0; k < C; k++) begin
        if (k == w) waits[k] = 0;
        else if (prev_req[k]) begin
          waits[k]++;
          check("fair", waits[k] <= C - 1, 1);
        end else waits[k] = 0;
      end
      cur_g = w; tx_cnt = 0; rx_cnt = 0; cs_falls = 0; rxq.delete(); stb_due = 1'b1;
      order.push_back(w);
      exp_cnt = (w < 0) ? 0 : ((drop_at[w] > 0) ? drop_at[w] : blen[w]);
    end else if (stb_due) begin
      check("lat", o_m_stb, 1);
      stb_due = 1'b0;
    end
    if (prev_gnt != '0 && o_gnt != '0) check("gnt_hold", o_gnt, prev_gnt);

    if (cur_g >= 0) begin
      wm = '0;
      wm[cur_g] = 1'b1;
      if (o_m_stb) begin
        check("tx", o_m_data, words[cur_g][tx_cnt % 8]);
        rxq.push_back(words[cur_g][tx_cnt % 8] ^ 8'h99);
        tx_cnt++;
      end
      if (o_rstb != '0) begin
        check("rstb", {o_rstb, o_gnt}, {wm, wm});
        check("rx_q", rxq.size() > 0, 1);
        if (rxq.size() > 0) check("rx", o_rdata, rxq.pop_front());
        rx_cnt++;
      end
      if (prev_cs[cur_g] && !o_cs[cur_g]) cs_falls++;
    end else begin
      check("idle_out", {o_m_stb, o_rstb, o_ack}, '0);
    end

    if (prev_gnt != '0 && o_gnt == '0 && cur_g >= 0) begin
      check("n_tx", tx_cnt, exp_cnt);
      check("n_rx", rx_cnt, tx_cnt);
      check("cs_pulse", cs_falls, 1);
      last_ntx = tx_cnt;
      mptr  = (cur_g + 1) % C;
      cur_g = -1;
    end
    prev_gnt = o_gnt;
    prev_cs  = o_cs;

    for (int k = 0; k < C; k++) begin
      if (o_ack[k]) begin
        acks[k]++;
        bidx[k]++;
        if (bidx[k] >= blen[k] || acks[k] == drop_at[k]) begin
          pend[k] = 1'b0;
          if (left[k] > 0) begin
            left[k]--;
            new_burst(k, 1, 0);
          end
        end
      end else if (rand_en && !pend[k] && !o_gnt[k] && $urandom_range(0, 3) == 0) begin
        int len, drop;
        len  = $urandom_range(1, 4);
        drop = (len > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, len - 1) : 0;
        new_burst(k, len, drop);
      end
    end
    arm();
  endtask

  task automatic run_idle(input int maxc);
    int n;
    bit done, anyp;
    n = 0;
    done = 1'b0;
    while (!done && n < maxc) begin
      step();
      n++;
      anyp = 1'b0;
      for (int k = 0; k < C; k++) anyp |= pend[k];
      done = !anyp && o_gnt == '0 && !m_busy && cur_g < 0;
    end
    check("timeout", done, 1);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; rand_en = 1'b0; last_ntx = 0;
    clear_clients();
    mon_reset();
    rst = 1'b1;
    arm();
    repeat (3) @(negedge clk);
    check("rst_gnt", o_gnt, '0);
    check("rst_cs", o_cs, 4'hF);
    check("rst_ack", o_ack, '0);
    check("rst_rstb", o_rstb, '0);
    check("rst_mstb", o_m_stb, 0);
    check("rst_mdata", o_m_data, '0);
    check("rst_rdata", o_rdata, '0);
    rst = 1'b0;

    // single one-word burst from client 0
    new_burst(0, 1, 0);
    words[0][0] = 8'hA5;
    arm();
    run_idle(200);
    check("t1_rdata", o_rdata, 8'h3C);
    check("t1_who", order[order.size()-1], 0);

    // three-word burst from client 2
    new_burst(2, 3, 0);
    words[2][0] = 8'h11; words[2][1] = 8'h22; words[2][2] = 8'h33;
    arm();
    run_idle(300);
    check("t2_rdata", o_rdata, 8'h33 ^ 8'h99);
    check("t2_ntx", last_ntx, 3);

    // client 1 drops its request after the first word
    new_burst(1, 3, 1);
    arm();
    run_idle(300);
    check("t3_who", order[order.size()-1], 1);
    check("t3_ntx", last_ntx, 1);

    // reset during the second word of a burst
    new_burst(3, 3, 0);
    arm();
    n = 0;
    while (tx_cnt < 2 && n < 100) begin
      step();
      n++;
    end
    check("t4_reach", tx_cnt, 2);
    rst = 1'b1;
    #1;
    check("t4_cs", o_cs, 4'hF);
    check("t4_gnt", o_gnt, '0);
    check("t4_mstb", o_m_stb, 0);
    check("t4_ack", o_ack, '0);
    clear_clients();
    arm();
    repeat (2) @(negedge clk);
    mon_reset();
    rst = 1'b0;

    // contention: all clients hold requests for two one-word bursts each
    order.delete();
    for (int k = 0; k < C; k++) begin
      new_burst(k, 1, 0);
      left[k] = 1;
    end
    arm();
    run_idle(600);
    check("t5_n", order.size(), 2 * C);
    for (int i = 0; i < 5; i++) check("t5_ord", order[i], i % C);

    // randomized traffic
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    run_idle(800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter that shares one `spi_master` instance between CLIENTS independent requesters. Each grant covers one burst of words ending with a client-marked last word. The arbiter feeds each burst into the master back-to-back through the master's shadow register, so the burst runs as a single chip-select frame. It routes received words back to the granted client and drives one chip-select per client. It sits between the client logic and the master's parallel port.

## Interface
Parameters:
- CLIENTS, 4 — number of requesters, ≥2.
- BITS, 8 — SPI word width; must equal the master's BITS.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  CLIENTS  per-client burst request; held high until the last word is acked.
- i_data  in  CLIENTS*BITS  per-client TX word; client k occupies bits [k*BITS +: BITS].
- i_last  in  CLIENTS  the current word of client k is the last of its burst.
- o_ack  out  CLIENTS  one-cycle pulse: the current word of client k has been taken; the client presents its next word on the following cycle.
- o_gnt  out  CLIENTS  one-hot grant; all zero when idle.
- o_rdata  out  BITS  last received word, shared by all clients.
- o_rstb  out  CLIENTS  one-cycle pulse to the granted client: o_rdata is valid.
- o_cs  out  CLIENTS  per-client chip-select, active-low.
- o_m_data  out  BITS  word to the master.
- o_m_stb  out  1  word strobe to the master.
- i_m_empty  in  1  master shadow register empty.
- i_m_busy  in  1  master running (chip-select asserted).
- i_m_data  in  BITS  master received word.
- i_m_stb  in  1  master received-word strobe.

## Operation
States: IDLE, FIRST, ISSUED, FEED, DRAIN.

- **IDLE:** o_gnt=0. If any i_req is set, select a winner by round-robin, searching from ptr upward with wrap. Go to FIRST and register o_gnt one-hot.
- **FIRST:**
  - Drive o_m_data = granted i_data, o_m_stb=1 and o_ack[g]=1 for one cycle.
  - Latch last_seen = i_last[g].
  - Go to ISSUED.
- **ISSUED:** single wait cycle so the master's i_m_busy and i_m_empty reflect the strobe. Next state is DRAIN if last_seen, otherwise FEED.
- **FEED:**
  - When i_m_busy & i_m_empty & i_req[g]: issue o_m_stb with o_ack[g] and latch last_seen. Go to ISSUED.
  - If i_req[g] drops while in FEED, treat the burst as ended and go to DRAIN.
- **DRAIN:** wait for i_m_busy=0. Then set ptr = g+1 (mod CLIENTS) and go to IDLE.
- **Chip-select:** o_cs[k] = ~(o_gnt[k] & i_m_busy). Non-granted clients always read 1.
- **Receive path:** every i_m_stb while o_gnt≠0 produces o_rdata ← i_m_data (registered) and o_rstb[g]=1 on the next cycle. An i_m_stb with o_gnt=0 is ignored.
- Reset values: state IDLE, ptr 0, o_gnt 0, o_ack 0, o_rstb 0, o_m_stb 0, o_m_data 0, o_rdata 0, o_cs all 1.
- **Reset mid-burst:** all outputs return immediately to their reset values. The master must share the same reset.

## Timing
- Request to first o_m_stb: 2 cycles (IDLE sample, then FIRST).
- o_m_stb, o_ack and o_rstb are registered single-cycle pulses. o_m_data is stable during o_m_stb.
- Between strobes there are at least 2 cycles (ISSUED plus one FEED evaluation).
- The master refills its shadow register within one word time, so bursts are gapless on SCK provided PSC≥1.
- o_rstb[g] follows i_m_stb by 1 cycle. The last received word of a burst is delivered before or in the same cycle as the transition from DRAIN to IDLE, never after o_gnt changes.
- Fairness: a continuously requesting client waits at most CLIENTS−1 bursts.
- If i_req of a non-granted client rises during a grant, it has no effect until IDLE.

## Structure
- Package `spi_arb_pkg`: state encoding localparams (STATE_BITS=3, the five states) and a CLIENTS-to-pointer-width function.
- Sub-module `spi_arb_rr_pick`: combinational round-robin one-hot picker with inputs req and ptr, and outputs gnt and idx.
- The top level holds the FSM, ptr, last_seen and the output registers.

## Test plan
- Single burst: client 0 sends 1 word 0xA5 with i_last=1, slave echoes 0x3C. Expect one o_m_stb; o_cs[0] low during the frame; o_rstb[0] with o_rdata=0x3C; o_gnt back to 0.
- 3-word burst: client 2 sends 0x11, 0x22, 0x33 (last). Expect 3 acks; a single o_cs[2] low pulse with no deassertion between words; 3 o_rstb[2] pulses.
- Contention: i_req = 4'b1111 held, each client sending 1-word bursts. Grants must occur in order 0,1,2,3,0 and no client's o_cs is low while another's is low.
- Early drop: client 1 deasserts i_req after its first ack without i_last. Expect DRAIN, one word transferred, and a clean return to IDLE.
- Reset mid-transfer: assert i_rst during the 2nd word. Expect all o_cs=1 and o_gnt=0 in the same cycle; after release, client 0 wins first.
